// File: rtl/i2s_pkg.sv
// i2s_pkg: slot geometry and FSM state type shared by the I2S transmitter.
package i2s_pkg;
    localparam int SLOT_W = 32;
    localparam int MSB_OFFSET = 1;
    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} i2s_state_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to BCLK and flags the clk before each BCLK edge.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic fall_tick,
    output logic rise_tick
);
    logic [7:0] cnt;
    logic       wrap;

    assign wrap      = en && (cnt == 8'(CLK_DIV - 1));
    assign fall_tick = wrap && bclk;
    assign rise_tick = wrap && !bclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono sample to stereo I2S serializer with 1-entry hold register.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a 16-bit saturating underrun counter port.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam logic [4:0] BIT_LO = 5'(MSB_OFFSET);
    localparam logic [4:0] BIT_HI = 5'(MSB_OFFSET + DATA_W - 1);

    i2s_state_t        state, state_nxt;
    logic              full, load_q, load, slot_end, in_data;
    logic              fall_tick, rise_tick;
    logic [DATA_W-1:0] hold, shreg, copy, load_val;
    logic [4:0]        bit_cnt;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk      (clk),
        .rst      (rst),
        .en       (state != S_IDLE),
        .bclk     (bclk),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    // bit_cnt advances on BCLK rise, so at each fall it already names the period starting
    assign slot_end = fall_tick && (bit_cnt == 5'd0);
    assign in_data  = (bit_cnt >= BIT_LO) && (bit_cnt <= BIT_HI);
    assign load_val = full ? hold : '0;
    assign in_ready = ~full;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = full ? S_LEFT : S_IDLE;
                load      = full;
            end
            S_LEFT:  state_nxt = slot_end ? S_RIGHT : S_LEFT;
            S_RIGHT: begin
                state_nxt = slot_end ? S_LEFT : S_RIGHT;
                load      = slot_end;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            full     <= 1'b0;
            load_q   <= 1'b0;
            hold     <= '0;
            shreg    <= '0;
            copy     <= '0;
            bit_cnt  <= '0;
            lrck     <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            load_q   <= load && full;
            underrun <= load && !full;
            // the hold register frees one clk after the load that drained it
            if (in_valid && !full) begin
                full <= 1'b1;
                hold <= data_in;
            end else if (load_q) begin
                full <= 1'b0;
            end
            if (rise_tick) bit_cnt <= bit_cnt + 5'd1;
            if (slot_end) lrck <= ~lrck;
            if (fall_tick) sdata <= in_data && shreg[DATA_W-1];
            if (load) begin
                shreg <= load_val;
                copy  <= load_val;
            end else if (slot_end) begin
                shreg <= copy;
            end else if (fall_tick && in_data) begin
                shreg <= {shreg[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) underrun_cnt <= '0;
        else if (load && !full && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed scoreboard bench for i2s_tx with CLK_DIV=2.
module tb_i2s_tx;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
    logic [23:0] data_in = '0;
    logic        in_ready, bclk, lrck, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    typedef struct {
        logic [23:0] s;
        int          acc;
    } entry_t;

    entry_t      q[$];
    entry_t      e;
    logic [23:0] cur = '0;
    logic [31:0] word = '0;
    logic        started = 1'b0, pl = 1'b0, pb = 1'b0, slot = 1'b0, side = 1'b0;
    int          idx = 0, und_seen = 0, und_exp = 0;
    int          vectors = 0, errors = 0, cyc = 0;

    i2s_tx #(.CLK_DIV(CLK_DIV), .DATA_W(24)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .bclk(bclk), .lrck(lrck), .sdata(sdata), .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame model: a sample feeds the frame whose load edge comes strictly after its accept edge.
    always @(negedge clk) begin
        if (!rst) begin
            started = 1'b0;
            pl = 1'b0;
            pb = 1'b0;
            idx = 0;
        end else begin
            if (underrun) und_seen++;
            if (pl && !lrck) begin
                if (q.size() > 0 && q[0].acc < cyc) begin
                    e = q.pop_front();
                    cur = e.s;
                    chk("underrun_pulse", underrun, 0);
                end else begin
                    cur = '0;
                    und_exp++;
                    chk("underrun_pulse", underrun, 1);
                end
                slot = 1'b0;
            end
            if (bclk && !pb) begin
                if (!started) begin
                    started = 1'b1;
                    slot = 1'b0;
                    chk("first_frame_queued", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        cur = e.s;
                    end
                end
                if (idx == 0) side = lrck;
                word = {word[30:0], sdata};
                if (idx == 31) begin
                    chk("slot_data", word, {1'b0, cur, 7'b0});
                    chk("slot_side", side, slot);
                    slot = 1'b1;
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            pl = lrck;
            pb = bclk;
        end
    end

    task automatic send(input logic [23:0] s, output int acc, output int fall);
        int   n = 0;
        logic p = lrck;
        fall = -1;
        data_in = s;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
            if (p && !lrck) fall = cyc;
            p = lrck;
        end
        chk("accept_timeout", n < 2000, 1);
        acc = cyc + 1;
        q.push_back('{s, acc});
        @(negedge clk);
    endtask

    task automatic wait_fall(output int f);
        int   n = 0;
        logic p = lrck;
        f = -1;
        while (f < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (p && !lrck) f = cyc;
            p = lrck;
        end
        chk("lrck_fall_timeout", f >= 0, 1);
        #1;
    endtask

    initial begin
        int a1, a2, a3, f, f1, f2, n, base;
        repeat (3) @(negedge clk);
        chk("rst_bclk", bclk, 0);
        chk("rst_lrck", lrck, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_underrun", underrun, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
        rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_bclk", bclk, 0);
        chk("idle_lrck", lrck, 0);

        send(24'hA5A5A5, a1, f);
        in_valid = 1'b0;
        wait_fall(f1);
        chk("underrun_seen", und_seen, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt_1", underrun_cnt, 1);
`endif
        wait_fall(f2);
        chk("lrck_period", f2 - f1, 256);

        send(24'h000001, a1, f);
        send(24'h000002, a2, f);
        chk("ready_after_load_2", a2 - f, 2);
        send(24'h000003, a3, f);
        chk("ready_after_load_3", a3 - f, 2);
        chk("accept_interval", a3 - a2, 256);

        send(24'h7FFFFF, a1, f);
        send(24'h800000, a2, f);
        in_valid = 1'b0;
        wait_fall(f);
        wait_fall(f);
        chk("queue_drained", q.size(), 0);
        chk("underrun_total", und_seen, und_exp);

        send(24'h123456, a1, f);
        in_valid = 1'b0;
        wait_fall(f);
        n = 0;
        while (!lrck && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("lrck_rise_timeout", n < 2000, 1);
        for (int i = 0; i < 10; i++) begin
            n = 0;
            @(negedge clk);
            while (!(pb && !bclk) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        #2;
        rst = 1'b0;
        base = und_exp;
        q.delete();
        #1;
        chk("midrst_sdata", sdata, 0);
        chk("midrst_bclk", bclk, 0);
        chk("midrst_lrck", lrck, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_underrun", underrun, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle_bclk", bclk, 0);

        send(24'h654321, a1, f);
        in_valid = 1'b0;
        wait_fall(f);
        wait_fall(f);
        chk("post_rst_drained", q.size(), 0);
        chk("underrun_final", und_seen, und_exp);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("underrun_cnt_after_rst", underrun_cnt, und_exp - base);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
